gem_fiber_in: RTL

Receive-side frame decoder for the fixed-latency GEM trigger link. It sits behind the trigger GTX receiver in the TRG_CLK80 domain and consumes the 32-bit/4-bit-K word stream the OptoHybrid trigger transmitter emits. Each 56-bit GEM cluster frame is sent as two words: a data word, then a word ending in a K-code frame separator. The block acquires word phase, reassembles each frame and flags overflow frames. It tracks the BC/F7/FB/FD bunch-sequence rotation, maintains link lock and counts link errors.

---
 rtl/gem_fiber_in.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gem_fiber_in.sv
// gem_fiber_in
// Receive-side frame decoder for the fixed-latency GEM trigger link.
// Consumes the 32-bit word / 4-bit K-flag stream from the trigger GTX receiver.
// It acquires word phase, reassembles each 56-bit cluster frame (a D word
// followed by a K-terminated word) and tracks the BC/F7/FB/FD separator
// rotation. It also maintains link lock and counts bad frames.
//
// Ports
//   TRG_CLK80     in   1   word clock
//   TRG_RST_N     in   1   asynchronous active-low reset
//   RX_DATA       in  32   received word, byte 0 = [7:0]
//   RX_ISK        in   4   per-byte K flags
//   CNT_CLR       in   1   synchronous clear of ERR_CNT (wins over increment)
//   GEM_DATA      out 56   last accepted frame
//   GEM_OVERFLOW  out  1   last accepted frame carried the FC separator
//   DATA_VALID    out  1   one-cycle pulse per frame accepted while locked
//   BX_PHASE      out  2   separator index of last frame (BC,F7,FB,FD = 0..3)
//   LOCKED        out  1   link locked
//   IDLE_SEEN     out  1   previous word was the idle word
//   SEP_ERR       out  1   one-cycle pulse per bad frame while locked
//   ERR_CNT       out 16   saturating bad-frame count
//
// state  | meaning
// -------+-----------------------------------------------------------------
// HUNT   | waiting for a rotation separator (BC/F7/FB/FD) to fix word phase
// SYNC   | phase assumed, counting consecutive good frames towards lock
// LOCKED | link up; frames delivered, bad frames counted

module gem_fiber_in #(
    parameter int LOCK_FRAMES = 4,
    parameter int UNLOCK_ERRS = 2
) (
    input  logic        TRG_CLK80,
    input  logic        TRG_RST_N,
    input  logic [31:0] RX_DATA,
    input  logic [3:0]  RX_ISK,
    input  logic        CNT_CLR,
    output logic [55:0] GEM_DATA,
    output logic        GEM_OVERFLOW,
    output logic        DATA_VALID,
    output logic [1:0]  BX_PHASE,
    output logic        LOCKED,
    output logic        IDLE_SEEN,
    output logic        SEP_ERR,
    output logic [15:0] ERR_CNT
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_SYNC   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    // word classification
    logic [7:0] sep;
    logic [1:0] sep_idx;
    logic       sep_rot;
    logic       sep_fc;
    logic       is_d;
    logic       is_k;
    logic       is_i;
    logic       is_x;

    assign sep = RX_DATA[7:0];

    always_comb begin
        sep_rot = 1'b1;
        sep_idx = 2'd0;
        case (sep)
            8'hBC:   sep_idx = 2'd0;
            8'hF7:   sep_idx = 2'd1;
            8'hFB:   sep_idx = 2'd2;
            8'hFD:   sep_idx = 2'd3;
            default: sep_rot = 1'b0;
        endcase
        sep_fc = (sep == 8'hFC);
        is_d   = (RX_ISK == 4'b0000);
        is_k   = (RX_ISK == 4'b0001) && (sep_rot || sep_fc);
        is_i   = (RX_ISK == 4'b0101) && (RX_DATA == 32'h50BC50BC);
        is_x   = !(is_d || is_k || is_i);
    end

    // state
    logic [1:0]    state_q, state_d;
    logic          ph_q, ph_d;          // 0: expecting D slot, 1: expecting K slot
    logic [1:0]    exp_q, exp_d;        // expected separator index
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [31:0]   hold_q, hold_d;
    logic [55:0]   gem_q, gem_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    bx_q, bx_d;
    logic          dv_q, dv_d;
    logic          serr_q, serr_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic          locked_q;
    logic          idle_q;
    logic          frame_good;
    logic          frame_bad;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        exp_d      = exp_q;
        good_d     = good_q;
        bad_d      = bad_q;
        hold_d     = hold_q;
        gem_d      = gem_q;
        ovf_d      = ovf_q;
        bx_d       = bx_q;
        dv_d       = 1'b0;
        serr_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;

        if (is_i) begin
            state_d = S_HUNT;
            ph_d    = 1'b0;
            good_d  = '0;
            bad_d   = '0;
        end else if (state_q == S_HUNT) begin
            // FC carries no rotation position, so it cannot seed exp
            if (is_k && sep_rot) begin
                state_d = S_SYNC;
                ph_d    = 1'b0;
                exp_d   = sep_idx + 2'd1;
                good_d  = '0;
                bad_d   = '0;
            end
        end else if (state_q == S_SYNC || state_q == S_LOCKED) begin
            // slot check; on a wrong class the received word redefines the phase
            if (is_x) begin
                frame_bad = 1'b1;
                ph_d      = ~ph_q;
            end else if (!ph_q) begin
                if (is_d) begin
                    hold_d = RX_DATA;
                    ph_d   = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                    ph_d      = 1'b0;
                end
            end else if (is_k) begin
                ph_d = 1'b0;
                if (sep_fc || sep_idx == exp_q) begin
                    frame_good = 1'b1;
                    exp_d      = exp_q + 2'd1;
                    gem_d      = {hold_q, RX_DATA[31:8]};
                    ovf_d      = sep_fc;
                    bx_d       = exp_q;
                end else begin
                    // re-align rotation so a single slip costs one error
                    frame_bad = 1'b1;
                    exp_d     = sep_idx + 2'd1;
                end
            end else begin
                frame_bad = 1'b1;
                hold_d    = RX_DATA;
                ph_d      = 1'b1;
            end

            if (state_q == S_SYNC) begin
                if (frame_bad) begin
                    state_d = S_HUNT;
                    ph_d    = 1'b0;
                end else if (frame_good) begin
                    if (good_q == GW'(LOCK_FRAMES - 1)) begin
                        state_d = S_LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end
            end else begin
                if (frame_bad) begin
                    serr_d = 1'b1;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (bad_q == BW'(UNLOCK_ERRS - 1)) begin
                        state_d = S_HUNT;
                        ph_d    = 1'b0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + BW'(1);
                    end
                end else if (frame_good) begin
                    dv_d  = 1'b1;
                    bad_d = '0;
                end
            end
        end else begin
            state_d = S_HUNT;
        end

        if (CNT_CLR) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
        if (!TRG_RST_N) begin
            state_q   <= S_HUNT;
            ph_q      <= 1'b0;
            exp_q     <= 2'd0;
            good_q    <= '0;
            bad_q     <= '0;
            hold_q    <= '0;
            gem_q     <= '0;
            ovf_q     <= 1'b0;
            bx_q      <= 2'd0;
            dv_q      <= 1'b0;
            serr_q    <= 1'b0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
            idle_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            exp_q     <= exp_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            hold_q    <= hold_d;
            gem_q     <= gem_d;
            ovf_q     <= ovf_d;
            bx_q      <= bx_d;
            dv_q      <= dv_d;
            serr_q    <= serr_d;
            err_cnt_q <= err_cnt_d;
            locked_q  <= (state_d == S_LOCKED);
            idle_q    <= is_i;
        end
    end

    assign GEM_DATA     = gem_q;
    assign GEM_OVERFLOW = ovf_q;
    assign DATA_VALID   = dv_q;
    assign BX_PHASE     = bx_q;
    assign LOCKED       = locked_q;
    assign IDLE_SEEN    = idle_q;
    assign SEP_ERR      = serr_q;
    assign ERR_CNT      = err_cnt_q;

endmodule
